pc_fetch_unit: RTL and testbench

- Parametrised successor to the fixed-vector PC register in the pipelined MIPS core; sits in the IF stage and drives the instruction-memory address.
- Adds:
  - parametrised reset and exception vectors;
  - prioritised next-PC selection (exception, ERET, branch/jump, stall, sequential);
  - a valid/ready fetch handshake;
  - a one-entry pending-redirect buffer, so redirects that arrive while a fetch is outstanding are never lost.

---
 rtl/pc_pkg.sv | 11 +
 rtl/pc_redirect_buffer.sv | 37 +++
 rtl/pc_fetch_unit.sv | 78 +++++++
 tb/tb_pc_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared PC constants and redirect-class encoding for the fetch unit and hazard unit
package pc_pkg;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;
    typedef enum logic [1:0] {
        RC_NONE   = 2'd0,
        RC_BRANCH = 2'd1,
        RC_ERET   = 2'd2,
        RC_EXC    = 2'd3
    } redir_class_e;
endpackage

// File: rtl/pc_redirect_buffer.sv
// pc_redirect_buffer: one-entry store for redirects that arrive while a fetch is outstanding
//   clk, Reset       clock, sync active-high reset
//   imem_ready       fetch completes this cycle; the entry is consumed and cleared
//   cls, target      redirect class and target presented this cycle
//   pend_valid       an entry is held
//   pend_kill        held entry is exception/ERET class (kills the in-flight fetch)
//   pend_target      held target address
module pc_redirect_buffer
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              imem_ready,
    input  redir_class_e      cls,
    input  logic [ADDR_W-1:0] target,
    output logic              pend_valid,
    output logic              pend_kill,
    output logic [ADDR_W-1:0] pend_target
);
    // Exception-class entries always overwrite; a branch never displaces a kill-class entry.
    always_ff @(posedge clk) begin
        if (Reset || imem_ready) begin
            pend_valid <= 1'b0;
            pend_kill  <= 1'b0;
        end else if (cls == RC_EXC || cls == RC_ERET) begin
            pend_valid  <= 1'b1;
            pend_kill   <= 1'b1;
            pend_target <= target;
        end else if (cls == RC_BRANCH && !(pend_valid && pend_kill)) begin
            pend_valid  <= 1'b1;
            pend_kill   <= 1'b0;
            pend_target <= target;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage program counter with prioritised next-PC selection and fetch handshake
//   clk, Reset                 clock, sync active-high reset
//   stall                      hazard hold; freezes sequential advance and ignores redirect
//   redirect, redirect_target  branch/jump target (applies after the delay slot)
//   exc_req                    exception entry; loads EXC_VECTOR
//   eret, epc_in               return from exception to epc_in
//   imem_ready                 instruction memory completes the current fetch
//   pc, pc_plus4               current fetch address and its sequential successor
//   fetch_req                  fetch valid (low only during reset)
//   fetch_kill                 returned instruction is wrong-path
//   fetch_adel                 fetch address misaligned
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc_in,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_req,
    output logic              fetch_kill,
    output logic              fetch_adel
);
    redir_class_e      cls;
    logic [ADDR_W-1:0] cls_target;
    logic              pend_valid;
    logic              pend_kill;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] pc_next;

    // Redirect stalled by the hazard unit is dropped; it will be re-presented.
    always_comb begin
        cls        = exc_req ? RC_EXC : eret ? RC_ERET : (redirect && !stall) ? RC_BRANCH : RC_NONE;
        cls_target = exc_req ? EXC_VECTOR : eret ? epc_in : redirect_target;
    end

    pc_redirect_buffer #(.ADDR_W(ADDR_W)) u_buf (
        .clk         (clk),
        .Reset       (Reset),
        .imem_ready  (imem_ready),
        .cls         (cls),
        .target      (cls_target),
        .pend_valid  (pend_valid),
        .pend_kill   (pend_kill),
        .pend_target (pend_target)
    );

    // A pending redirect outranks a fresh branch but not a fresh exception/ERET.
    always_comb begin
        pc_next = !imem_ready                          ? pc :
                  (cls == RC_EXC || cls == RC_ERET)    ? cls_target :
                  pend_valid                           ? pend_target :
                  (cls == RC_BRANCH)                   ? cls_target :
                  stall                                ? pc : pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (Reset)
            pc <= RESET_VECTOR;
        else
            pc <= pc_next;
    end

    assign pc_plus4   = pc + ADDR_W'(4);
    assign fetch_req  = !Reset;
    assign fetch_adel = fetch_req && (pc[1:0] != 2'b00);
    assign fetch_kill = imem_ready && (exc_req || eret || (pend_valid && pend_kill));
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit against a behavioural reference model
module tb_pc_fetch_unit;
    localparam logic [31:0] RV = 32'h0000_3000;
    localparam logic [31:0] EV = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc_in = '0;
    logic        imem_ready = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_req;
    logic        fetch_kill;
    logic        fetch_adel;

    pc_fetch_unit dut (
        .clk             (clk),
        .Reset           (Reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .eret            (eret),
        .epc_in          (epc_in),
        .imem_ready      (imem_ready),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_req       (fetch_req),
        .fetch_kill      (fetch_kill),
        .fetch_adel      (fetch_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
        logic        req;
        logic        kill;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: architectural PC plus an optional parked redirect.
    logic [31:0] m_pc = RV;
    logic        m_pv = 1'b0;
    logic        m_pk = 1'b0;
    logic [31:0] m_pt = '0;

    // Monitor: every cycle the DUT presents outputs; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 5;
            if (pc !== e.pc) begin errors++; $display("FAIL pc: got %h want %h at %0t", pc, e.pc, $time); end
            if (pc_plus4 !== e.p4) begin errors++; $display("FAIL pc_plus4: got %h want %h at %0t", pc_plus4, e.p4, $time); end
            if (fetch_req !== e.req) begin errors++; $display("FAIL fetch_req: got %b want %b at %0t", fetch_req, e.req, $time); end
            if (fetch_kill !== e.kill) begin errors++; $display("FAIL fetch_kill: got %b want %b at %0t", fetch_kill, e.kill, $time); end
            if (fetch_adel !== e.adel) begin errors++; $display("FAIL fetch_adel: got %b want %b at %0t", fetch_adel, e.adel, $time); end
        end
    end

    task automatic chk_pc(input string name, input logic [31:0] want);
        checks++;
        if (pc !== want) begin
            errors++;
            $display("FAIL %s: pc got %h want %h", name, pc, want);
        end
    endtask

    // Drive one cycle, push the expected outputs, advance the model, then wait for the edge.
    task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rt,
                       input logic ex, input logic er, input logic [31:0] epc, input logic rdy);
        exp_t e;
        Reset = r; stall = st; redirect = rd; redirect_target = rt;
        exc_req = ex; eret = er; epc_in = epc; imem_ready = rdy;
        e.pc   = m_pc;
        e.p4   = m_pc + 32'd4;
        e.req  = !r;
        e.adel = !r && (m_pc[1:0] != 2'b00);
        e.kill = rdy && (ex || er || (m_pv && m_pk));
        exp_q.push_back(e);
        if (r) begin
            m_pc = RV; m_pv = 1'b0; m_pk = 1'b0;
        end else if (rdy) begin
            if (ex)                m_pc = EV;
            else if (er)           m_pc = epc;
            else if (m_pv)         m_pc = m_pt;
            else if (rd && !st)    m_pc = rt;
            else if (!st)          m_pc = m_pc + 32'd4;
            m_pv = 1'b0; m_pk = 1'b0;
        end else if (ex) begin
            m_pt = EV; m_pk = 1'b1; m_pv = 1'b1;
        end else if (er) begin
            m_pt = epc; m_pk = 1'b1; m_pv = 1'b1;
        end else if (rd && !st && !(m_pv && m_pk)) begin
            m_pt = rt; m_pk = 1'b0; m_pv = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic br(input logic [31:0] t, input logic rdy);
        cyc(1'b0, 1'b0, 1'b1, t, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) idle(1'b1);
        chk_pc("seq_after_reset", 32'h0000_3010);
        br(32'h0000_3100, 1'b1);
        chk_pc("redirect_ready", 32'h0000_3100);
        br(32'h0000_3010, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_pc("redirect_stalled", 32'h0000_3010);
        br(32'h0000_3020, 1'b1);
        br(32'h0000_3200, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk_pc("hold_outstanding", 32'h0000_3020);
        idle(1'b1);
        chk_pc("pending_branch", 32'h0000_3200);
        br(32'h0000_3300, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        br(32'h0000_3400, 1'b0);
        idle(1'b1);
        chk_pc("pending_exc", EV);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3006, 1'b1);
        chk_pc("eret", 32'h0000_3006);
        idle(1'b1);
        chk_pc("misaligned_advance", 32'h0000_300A);
        br(32'hFFFF_FFFC, 1'b1);
        idle(1'b1);
        chk_pc("wrap", 32'h0000_0000);
        br(32'h0000_3500, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b1);
        chk_pc("reset_drops_pending", 32'h0000_3004);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom_range(7) == 0 ? $urandom : {$urandom_range(32'h3FFF), 2'b00};
            cyc($urandom_range(99) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0, t,
                $urandom_range(29) == 0, $urandom_range(29) == 0, $urandom, $urandom_range(9) < 7);
        end
        idle(1'b1);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
